// File: rtl/div_issue_ctrl.sv
// Requester side of the divider Start/Ready handshake: latches DIV/DIVU operands, holds Start
// until Ready, writes {remainder, quotient} to HI/LO and stalls the pipe while a divide is open.
module div_issue_ctrl #(
    parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_valid,
    input  logic        ex_div_signed,
    input  logic [31:0] ex_rs,
    input  logic [31:0] ex_rt,
    input  logic        ex_flush,
    output logic        stall,
    output logic        busy,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [63:0] div_result,
    input  logic        div_ready,
    output logic        hilo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata
);

    typedef enum logic [2:0] {StIdle, StBusy, StDrain, StWb, StZero} state_e;

    state_e      state_q, state_d;
    logic        start_q, start_d;
    logic        signed_q, signed_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        we_q, we_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        stall_c;
    logic        accept;

    assign accept = ex_div_valid && !ex_flush;

    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        signed_d = signed_q;
        a_d      = a_q;
        b_d      = b_q;
        we_d     = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        stall_c  = 1'b0;
        unique case (state_q)
            StIdle: begin
                stall_c = accept;
                if (accept) begin
                    a_d      = ex_rs;
                    b_d      = ex_rt;
                    signed_d = ex_div_signed;
                    if (ex_rt == 32'd0) begin
                        hi_d    = ex_rs;
                        lo_d    = DIV0_LO;
                        we_d    = 1'b1;
                        state_d = StZero;
                    end else begin
                        start_d = 1'b1;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                stall_c = 1'b1;
                if (ex_flush) begin
                    state_d = StDrain;
                end else if (div_ready) begin
                    hi_d    = div_result[63:32];
                    lo_d    = div_result[31:0];
                    we_d    = 1'b1;
                    start_d = 1'b0;
                    state_d = StWb;
                end
            end
            // The divider cannot abort, so a cancelled divide runs to Ready and is discarded.
            StDrain: begin
                stall_c = ex_div_valid;
                if (div_ready) begin
                    start_d = 1'b0;
                    state_d = StWb;
                end
            end
            // Stay until Ready is seen low so the next Start reloads operands instead of resuming.
            StWb: begin
                stall_c = ex_div_valid && !we_q;
                if (!div_ready) begin
                    state_d = StIdle;
                end
            end
            StZero: begin
                stall_c = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            start_q  <= 1'b0;
            signed_q <= 1'b0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            we_q     <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            signed_q <= signed_d;
            a_q      <= a_d;
            b_q      <= b_d;
            we_q     <= we_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign stall      = rst && stall_c;
    assign busy       = (state_q != StIdle);
    assign div_start  = start_q;
    assign div_signed = signed_q;
    assign div_a      = a_q;
    assign div_b      = b_q;
    assign hilo_we    = we_q && !ex_flush;
    assign hi_wdata   = hi_q;
    assign lo_wdata   = lo_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: a latency-8 iterative divider model plus a vector table
// and directed flush / reset sequences.
module tb_div_issue_ctrl;

    localparam int LAT = 8;

    logic        clk;
    logic        rst;
    logic        ex_div_valid;
    logic        ex_div_signed;
    logic [31:0] ex_rs;
    logic [31:0] ex_rt;
    logic        ex_flush;
    logic        stall;
    logic        busy;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [63:0] div_result;
    logic        div_ready;
    logic        hilo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;

    int checks = 0;
    int errors = 0;

    div_issue_ctrl #(.DIV0_LO(32'hFFFF_FFFF)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_div_valid (ex_div_valid),
        .ex_div_signed(ex_div_signed),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_flush     (ex_flush),
        .stall        (stall),
        .busy         (busy),
        .div_start    (div_start),
        .div_signed   (div_signed),
        .div_a        (div_a),
        .div_b        (div_b),
        .div_result   (div_result),
        .div_ready    (div_ready),
        .hilo_we      (hilo_we),
        .hi_wdata     (hi_wdata),
        .lo_wdata     (lo_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Divider model: Ready rises after LAT-1 sampled Starts, clears in the low phase once
    // Start is dropped; a dropped Start before Ready freezes the count.
    int mcnt;
    always @(posedge clk or negedge clk or negedge rst) begin
        if (!rst) begin
            mcnt       <= 0;
            div_ready  <= 1'b0;
            div_result <= 64'd0;
        end else if (clk) begin
            if (div_start && !div_ready) begin
                if (mcnt == LAT - 2) begin
                    div_ready  <= 1'b1;
                    div_result <= ref_div(div_a, div_b, div_signed);
                end
                mcnt <= mcnt + 1;
            end
        end else begin
            if (!div_start && div_ready) begin
                div_ready <= 1'b0;
                mcnt      <= 0;
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        sgn;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] lo;
        logic [31:0] hi;
        int          starts;
        int          stalls;
    } vec_t;

    vec_t vecs[7];

    task automatic run_div(input vec_t v, input string tag);
        int   stalls = 0;
        int   starts = 0;
        int   cyc = 0;
        int   unstable = 0;
        int   sgn_bad = 0;
        int   w = 0;
        bit   seen = 0;
        logic [31:0] a0 = '0;
        logic [31:0] b0 = '0;
        @(negedge clk);
        ex_div_valid  = 1'b1;
        ex_div_signed = v.sgn;
        ex_rs         = v.rs;
        ex_rt         = v.rt;
        #1;
        while (!seen && cyc < 64) begin
            if (hilo_we) begin
                seen = 1;
                check({tag, " lo"}, lo_wdata, v.lo);
                check({tag, " hi"}, hi_wdata, v.hi);
                check({tag, " stall at write"}, stall, 1'b0);
            end else if (stall) begin
                stalls++;
            end
            if (div_start) begin
                if (starts == 0) begin
                    a0 = div_a;
                    b0 = div_b;
                end else if (div_a !== a0 || div_b !== b0) begin
                    unstable++;
                end
                if (div_signed !== v.sgn) sgn_bad++;
                starts++;
            end
            cyc++;
            @(negedge clk);
            if (seen) ex_div_valid = 1'b0;
            #1;
        end
        ex_div_valid = 1'b0;
        check({tag, " write seen"}, seen, 1'b1);
        check({tag, " stall cycles"}, stalls, v.stalls);
        check({tag, " start cycles"}, starts, v.starts);
        check({tag, " operands stable"}, unstable, 0);
        check({tag, " signed flag"}, sgn_bad, 0);
        check({tag, " latched a/b"}, {div_a, div_b}, {v.rs, v.rt});
        check({tag, " start low after"}, div_start, 1'b0);
        while (busy && w < 8) begin
            @(negedge clk);
            #1;
            w++;
        end
        check({tag, " back to idle"}, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int idx;
        int stalls;
        int run1;
        int wcnt;
        int w;
        bit dropped;
        bit seen;

        vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          8, 9};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  8, 9};
        vecs[2] = '{1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  0, 1};
        vecs[3] = '{1'b0, 32'hFFFF_FFFF,  32'd16,         32'h0FFF_FFFF,  32'h0000_000F,  8, 9};
        vecs[4] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          8, 9};
        vecs[5] = '{1'b1, 32'hFFFF_FF9C,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FF9C,  0, 1};
        vecs[6] = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          8, 9};

        rst           = 1'b0;
        ex_div_valid  = 1'b1;
        ex_div_signed = 1'b1;
        ex_rs         = 32'd5;
        ex_rt         = 32'd3;
        ex_flush      = 1'b0;
        #12;
        check("reset outputs",
              {stall, busy, div_start, div_signed, div_a, div_b, hilo_we, hi_wdata, lo_wdata},
              '0);
        ex_div_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) run_div(vecs[i], $sformatf("vec%0d", i));

        // Flush three cycles into 100/7 while 20/3 waits behind it.
        idx = 0; stalls = 0; run1 = 0; dropped = 0; seen = 0;
        @(negedge clk);
        ex_div_valid = 1'b1; ex_div_signed = 1'b0; ex_rs = 32'd100; ex_rt = 32'd7;
        #1;
        while (!seen && idx < 64) begin
            if (hilo_we) begin
                seen = 1;
                check("drain write index", idx, 19);
                check("drain second lo", lo_wdata, 32'd6);
                check("drain second hi", hi_wdata, 32'd2);
            end else if (stall) begin
                stalls++;
            end
            if (div_start && !dropped) run1++;
            else if (run1 > 0) dropped = 1;
            idx++;
            @(negedge clk);
            if (idx == 4) begin
                ex_flush = 1'b1; ex_rs = 32'd20; ex_rt = 32'd3;
            end else begin
                ex_flush = 1'b0;
            end
            if (seen) ex_div_valid = 1'b0;
            #1;
        end
        ex_div_valid = 1'b0;
        check("drain write seen", seen, 1'b1);
        check("drain start held to ready", run1, LAT);
        check("drain stall cycles", stalls, 19);

        // Flush coincident with Ready in BUSY.
        @(negedge clk);
        ex_div_valid = 1'b1; ex_div_signed = 1'b0; ex_rs = 32'd50; ex_rt = 32'd5;
        #1;
        w = 0;
        while (!div_ready && w < 20) begin
            @(negedge clk); #1; w++;
        end
        check("flush-ready saw ready", div_ready, 1'b1);
        ex_flush = 1'b1; ex_div_valid = 1'b0;
        wcnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (hilo_we) wcnt++;
            @(negedge clk);
            ex_flush = 1'b0;
            #1;
        end
        check("flush-ready no write", wcnt, 0);
        check("flush-ready idle", {busy, div_start}, 2'b00);

        // Flush coincident with the WB cycle.
        @(negedge clk);
        ex_div_valid = 1'b1; ex_div_signed = 1'b0; ex_rs = 32'd50; ex_rt = 32'd5;
        #1;
        w = 0;
        while (!div_ready && w < 20) begin
            @(negedge clk); #1; w++;
        end
        @(negedge clk);
        ex_flush = 1'b1; ex_div_valid = 1'b0;
        #1;
        check("flush-wb in wb", {busy, div_start}, 2'b10);
        check("flush-wb strobe gated", hilo_we, 1'b0);
        wcnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ex_flush = 1'b0;
            #1;
            if (hilo_we) wcnt++;
        end
        check("flush-wb no later write", wcnt, 0);
        check("flush-wb idle", busy, 1'b0);

        // Asynchronous reset in the middle of a signed divide.
        @(negedge clk);
        ex_div_valid = 1'b1; ex_div_signed = 1'b1; ex_rs = 32'd100; ex_rt = 32'd7;
        for (int k = 0; k < 4; k++) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mid-busy reset outputs",
              {stall, busy, div_start, div_signed, div_a, div_b, hilo_we, hi_wdata, lo_wdata},
              '0);
        @(negedge clk);
        ex_div_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_div('{1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 8, 9}, "post-reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
